// File: rtl/counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
// Holds the direction encodings and the elaboration-time legality check
// that every counter instance runs against its parameter set.
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when the parameter set describes a buildable counter:
    // 2 <= modulo <= 2**width, 0 <= reset_val < modulo, saturate is 0 or 1.
    function automatic bit params_legal(
        input int width,
        input int modulo,
        input int reset_val,
        input int saturate
    );
        longint unsigned span;
        if (width < 1 || width > 31) return 1'b0;
        span = 64'd1 << width;
        if (modulo < 2) return 1'b0;
        if (longint'(modulo) > longint'(span)) return 1'b0;
        if (reset_val < 0 || reset_val >= modulo) return 1'b0;
        if (saturate != 0 && saturate != 1) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/inc_edge_detect.sv
// Rising-edge detector for the counter step request.
// The history register clears on reset, so an input already high when
// reset releases counts as a fresh edge on the first free cycle.
module inc_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic r_prev_reg;

    // Remember the previous sample of the input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_reg <= 1'b0;
        end else begin
            r_prev_reg <= in;
        end
    end

    assign pulse = in & ~r_prev_reg;

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, optional saturation and a
// registered one-cycle carry/borrow pulse for cascading stages.
// Build option: define CNT_EDGE_INC_EN to make Inc rising-edge sensitive
// (one step per 0->1 transition); otherwise Inc steps once per cycle high.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int MODULO    = 60,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             UpDown,
    input  logic             Inc,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             carry
);

    // Top of range computed once; MODULO = 2**WIDTH gives all ones.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
    localparam bit               SAT_EN  = (SATURATE != 0);

    generate
        if (!params_legal(WIDTH, MODULO, RESET_VAL, SATURATE)) begin : g_bad_params
            $error("mod_updown_counter: illegal parameters WIDTH=%0d MODULO=%0d RESET_VAL=%0d SATURATE=%0d",
                   WIDTH, MODULO, RESET_VAL, SATURATE);
        end
    endgenerate

    logic [WIDTH-1:0] r_count_reg;
    logic             r_carry_reg;
    logic [WIDTH-1:0] w_count_next;
    logic             w_carry_next;
    logic             w_step;

`ifdef CNT_EDGE_INC_EN
    // An edge arriving together with load is swallowed: the history still
    // updates, but load wins the priority below.
    inc_edge_detect u_inc_edge (
        .clk   (clk),
        .reset (reset),
        .in    (Inc),
        .pulse (w_step)
    );
`else
    assign w_step = Inc;
`endif

    // Next-state selection: load beats step beats hold; reset is applied in
    // the register so a wrap during reset never leaks a carry.
    always_comb begin
        w_count_next = r_count_reg;
        w_carry_next = 1'b0;
        if (load) begin
            w_count_next = (load_val <= MAX_VAL) ? load_val : MAX_VAL;
        end else if (w_step) begin
            if (UpDown == DIR_UP) begin
                if (r_count_reg == MAX_VAL) begin
                    if (!SAT_EN) begin
                        w_count_next = '0;
                        w_carry_next = 1'b1;
                    end
                end else begin
                    w_count_next = r_count_reg + WIDTH'(1);
                end
            end else begin
                if (r_count_reg == '0) begin
                    if (!SAT_EN) begin
                        w_count_next = MAX_VAL;
                        w_carry_next = 1'b1;
                    end
                end else begin
                    w_count_next = r_count_reg - WIDTH'(1);
                end
            end
        end
    end

    // Count and carry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_reg <= RST_VAL;
            r_carry_reg <= 1'b0;
        end else begin
            r_count_reg <= w_count_next;
            r_carry_reg <= w_carry_next;
        end
    end

    assign count = r_count_reg;
    assign carry = r_carry_reg;
    assign tc    = ((UpDown == DIR_UP)   && (r_count_reg == MAX_VAL)) ||
                   ((UpDown == DIR_DOWN) && (r_count_reg == '0));

endmodule
